reg_writeback_ctrl: RTL and testbench

//  Write-port driver for the 32x32 register file: collects results from the single-cycle ALU path
//  and the multi-cycle memory/load path, orders them and issues one write per cycle
//  (regWrite/rd/writeData). Buffers memory results in a small FIFO with valid/ready backpressure.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_result_fifo.sv | 73 +++++++
 rtl/reg_writeback_ctrl.sv | 124 ++++++++++++
 tb/tb_reg_writeback_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
package wb_pkg;

    localparam int unsigned WB_DATA_W  = 32;
    localparam int unsigned WB_ADDR_W  = 5;
    localparam int unsigned WB_NUM_REG = 32;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Memory-result buffer: circular FIFO of {rd, data} entries with per-slot
// valid flags exported so the owner can build a pending-destination mask.
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  wb_entry_t                i_push_entry,
    input  logic                     i_pop,
    output wb_entry_t                o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output wb_entry_t                o_entries [DEPTH],
    output logic [DEPTH-1:0]         o_slot_valid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t         r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic              w_push;
    logic              w_pop;

    assign o_full       = (r_count == CW'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign w_push       = i_push && !o_full;
    assign w_pop        = i_pop && !o_empty;
    assign o_head       = r_mem[r_rd_ptr];
    assign o_count      = r_count;
    assign o_entries    = r_mem;
    assign o_slot_valid = r_valid;

    // Entry storage: data is written on push only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointers, occupancy and slot-valid flags; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write-port driver: merges the single-cycle ALU result stream
// with buffered memory results (ALU has priority), drops x0 writes, and
// publishes a pending-destination mask for hazard detection.
// Optional build macro WB_BYPASS_EN enables the writeback forwarding compare.
module reg_writeback_ctrl
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W     = WB_DATA_W,
    parameter int unsigned ADDR_W     = WB_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [ADDR_W-1:0]             alu_rd,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [ADDR_W-1:0]             mem_rd,
    input  logic [DATA_W-1:0]             mem_data,
    output logic                          regWrite,
    output logic [ADDR_W-1:0]             rd,
    output logic [DATA_W-1:0]             writeData,
    output logic [WB_NUM_REG-1:0]         pend_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    input  logic [ADDR_W-1:0]             rs1,
    input  logic [ADDR_W-1:0]             rs2,
    output logic                          fwd1_hit,
    output logic                          fwd2_hit,
    output logic [DATA_W-1:0]             fwd1_data,
    output logic [DATA_W-1:0]             fwd2_data
);

    logic                       w_alu_req;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_empty;
    wb_entry_t                  w_push_entry;
    wb_entry_t                  w_head;
    wb_entry_t                  w_entries [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]      w_slot_valid;
    logic [WB_NUM_REG-1:0]      w_pend;

    logic                       r_reg_write;
    logic [ADDR_W-1:0]          r_rd;
    logic [DATA_W-1:0]          r_write_data;

    // An ALU write to x0 is not a request, so it never blocks a FIFO pop.
    assign w_alu_req = alu_valid && (alu_rd != REG_ZERO);
    assign mem_ready = !rst && !w_full;
    // x0 memory results are handshaken but never stored.
    assign w_push    = mem_valid && mem_ready && (mem_rd != REG_ZERO);
    assign w_pop     = !w_alu_req && !w_empty;

    assign w_push_entry.rd   = mem_rd;
    assign w_push_entry.data = mem_data;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (fifo_count),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_entries    (w_entries),
        .o_slot_valid (w_slot_valid)
    );

    // Fixed-priority issue into the registered write port; rd/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            r_write_data <= '0;
        end else if (w_alu_req) begin
            r_reg_write  <= 1'b1;
            r_rd         <= alu_rd;
            r_write_data <= alu_data;
        end else if (!w_empty) begin
            r_reg_write  <= 1'b1;
            r_rd         <= w_head.rd;
            r_write_data <= w_head.data;
        end else begin
            r_reg_write  <= 1'b0;
        end
    end

    assign regWrite  = r_reg_write;
    assign rd        = r_rd;
    assign writeData = r_write_data;

    // Pending mask derived from registered FIFO slots, so it moves in step with fifo_count.
    always_comb begin
        w_pend = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (w_slot_valid[i]) begin
                w_pend[w_entries[i].rd] = 1'b1;
            end
        end
    end

    assign pend_mask = w_pend;

`ifdef WB_BYPASS_EN
    assign fwd1_hit  = r_reg_write && (r_rd == rs1) && (rs1 != REG_ZERO);
    assign fwd2_hit  = r_reg_write && (r_rd == rs2) && (rs2 != REG_ZERO);
    assign fwd1_data = r_write_data;
    assign fwd2_data = r_write_data;
`else
    logic w_unused_rs;
    assign w_unused_rs = ^{rs1, rs2};
    assign fwd1_hit    = 1'b0;
    assign fwd2_hit    = 1'b0;
    assign fwd1_data   = '0;
    assign fwd2_data   = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl; honours WB_BYPASS_EN for forwarding expectations.
module tb_reg_writeback_ctrl;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        regWrite;
    logic [4:0]  rd;
    logic [31:0] writeData;
    logic [31:0] pend_mask;
    logic [1:0]  fifo_count;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;

    int n_tests = 0;
    int n_fail  = 0;

    reg_writeback_ctrl #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .regWrite   (regWrite),
        .rd         (rd),
        .writeData  (writeData),
        .pend_mask  (pend_mask),
        .fifo_count (fifo_count),
        .rs1        (rs1),
        .rs2        (rs2),
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1;
        rs1 = '0; rs2 = '0;

        // Reset with memory offering
        tick();
        tick();
        check("rst_regWrite", regWrite, 0);
        check("rst_rd", rd, 0);
        check("rst_wdata", writeData, 0);
        check("rst_ready", mem_ready, 0);
        check("rst_count", fifo_count, 0);
        check("rst_pend", pend_mask, 0);
        rst = 1'b0; mem_valid = 1'b0;
        #1;
        check("ready_after_rst", mem_ready, 1);

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        tick();
        check("alu_we", regWrite, 1);
        check("alu_rd", rd, 5);
        check("alu_data", writeData, 32'hDEAD_BEEF);
        alu_rd = 5'd0; alu_data = 32'h123;
        tick();
        check("alu_x0_we", regWrite, 0);
        check("alu_x0_rd_hold", rd, 5);
        check("alu_x0_data_hold", writeData, 32'hDEAD_BEEF);
        alu_valid = 1'b0;

        // Single memory result: FIFO first, write a cycle later
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h11;
        tick();
        mem_valid = 1'b0;
        check("mem1_count", fifo_count, 1);
        check("mem1_we_not_yet", regWrite, 0);
        check("mem1_pend", pend_mask, 32'h0000_0080);
        tick();
        check("mem1_we", regWrite, 1);
        check("mem1_rd", rd, 7);
        check("mem1_data", writeData, 32'h11);
        check("mem1_count_after", fifo_count, 0);
        check("mem1_pend_after", pend_mask, 0);

        // ALU busy, FIFO fills, backpressure, then ordered drain
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h80;
        tick();
        check("fill1_count", fifo_count, 1);
        check("fill1_alu_rd", rd, 3);
        mem_rd = 5'd9; mem_data = 32'h90;
        tick();
        check("fill2_count", fifo_count, 2);
        check("fill2_pend", pend_mask, 32'h0000_0300);
        check("full_ready", mem_ready, 0);
        mem_rd = 5'd10; mem_data = 32'hA0;
        tick();
        check("full_count_hold", fifo_count, 2);
        check("full_pend_hold", pend_mask, 32'h0000_0300);
        check("full_alu_rd", rd, 3);
        mem_valid = 1'b0; alu_valid = 1'b0;
        tick();
        check("drain1_rd", rd, 8);
        check("drain1_data", writeData, 32'h80);
        check("drain1_count", fifo_count, 1);
        check("drain1_pend", pend_mask, 32'h0000_0200);
        check("drain1_ready", mem_ready, 1);
        tick();
        check("drain2_rd", rd, 9);
        check("drain2_data", writeData, 32'h90);
        check("drain2_pend", pend_mask, 0);
        tick();
        check("drain_idle_we", regWrite, 0);

        // Memory result to x0: handshaken, discarded
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFF;
        #1;
        check("x0_ready", mem_ready, 1);
        tick();
        mem_valid = 1'b0;
        check("x0_count", fifo_count, 0);
        tick();
        check("x0_no_write", regWrite, 0);

        // Simultaneous push and pop keeps count
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hC;
        tick();
        mem_rd = 5'd13; mem_data = 32'hD;
        tick();
        mem_valid = 1'b0;
        check("pp_rd", rd, 12);
        check("pp_count", fifo_count, 1);
        check("pp_pend", pend_mask, 32'h0000_2000);
        tick();
        check("pp_rd2", rd, 13);
        check("pp_count2", fifo_count, 0);

        // Forwarding compare
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h55;
        tick();
        alu_valid = 1'b0; rs1 = 5'd4; rs2 = 5'd0;
        #1;
`ifdef WB_BYPASS_EN
        check("fwd1_hit", fwd1_hit, 1);
        check("fwd1_data", fwd1_data, 32'h55);
`else
        check("fwd1_hit", fwd1_hit, 0);
        check("fwd1_data", fwd1_data, 0);
`endif
        check("fwd2_hit", fwd2_hit, 0);
        rs1 = '0;

        // Mid-run reset flushes buffered writes
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1;
        mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h20;
        tick();
        mem_rd = 5'd21; mem_data = 32'h21;
        tick();
        check("pre_flush_count", fifo_count, 2);
        mem_valid = 1'b0; alu_valid = 1'b0; rst = 1'b1;
        #1;
        check("flush_ready", mem_ready, 0);
        tick();
        check("flush_count", fifo_count, 0);
        check("flush_we", regWrite, 0);
        check("flush_pend", pend_mask, 0);
        rst = 1'b0;
        tick();
        check("post_flush_we1", regWrite, 0);
        tick();
        check("post_flush_we2", regWrite, 0);
        check("post_flush_rd", rd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
